gf2m_digit_serial_mult: RTL and testbench

Parametrised digit-serial multiplier over GF(2^M) with a pentanomial or trinomial reduction polynomial, for the ALU datapath of the Niederreiter cryptoprocessor. It succeeds the single-cycle GF(2^16) multiplier and adds three things: a configurable digit size D that trades area against latency, MUL/SQR/MAC operating modes, and valid/ready handshakes on input and output. Results are held until the downstream ALU accepts them.

---
 rtl/gf2m_pkg.sv | 19 +
 rtl/gf2m_digit_step.sv | 44 ++++
 rtl/gf2m_digit_serial_mult.sv | 118 +++++++++++
 tb/tb_gf2m_digit_serial_mult.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf2m_pkg.sv
// Shared definitions for the GF(2^M) digit-serial multiplier: op encodings,
// controller states and the digit-count helper.
package gf2m_pkg;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_SQR = 2'b01;
  localparam logic [1:0] OP_MAC = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic int calc_ndig(input int m, input int d);
    return (m + d - 1) / d;
  endfunction

endpackage

// File: rtl/gf2m_digit_step.sv
// One digit of the MSB-first multiply: acc_o = acc_i*x^D + a_i*digit_i mod f(x),
// evaluated as D chained Horner steps (multiply by x, reduce, conditionally add A).
module gf2m_digit_step #(
  parameter int M     = 16,
  parameter int K2    = 5,
  parameter int K1    = 3,
  parameter int K0    = 2,
  parameter int TRI_K = 0,
  parameter int D     = 4
) (
  input  logic [M-1:0] acc_i,
  input  logic [M-1:0] a_i,
  input  logic [D-1:0] digit_i,
  output logic [M-1:0] acc_o
);

  // Zero taps land on bit 0, which is always set, so ORing them in is harmless.
  function automatic logic [M-1:0] taps_fn();
    logic [M-1:0] t;
    t = '0;
    t[0] = 1'b1;
    if (K2 == 0 && K1 == 0 && K0 == 0) begin
      t = t | (M'(1) << TRI_K);
    end else begin
      t = t | (M'(1) << K0) | (M'(1) << K1) | (M'(1) << K2);
    end
    return t;
  endfunction

  localparam logic [M-1:0] TAPS = taps_fn();

  logic [M-1:0] chain [D+1];

  assign chain[0] = acc_i;

  for (genvar gi = 0; gi < D; gi++) begin : g_bit
    logic [M-1:0] shifted;
    assign shifted       = {chain[gi][M-2:0], 1'b0} ^ (chain[gi][M-1] ? TAPS : '0);
    assign chain[gi + 1] = shifted ^ (digit_i[D-1-gi] ? a_i : '0);
  end

  assign acc_o = chain[D];

endmodule

// File: rtl/gf2m_digit_serial_mult.sv
// Digit-serial GF(2^M) multiplier with MUL/SQR/MAC modes and valid/ready
// handshakes; one digit of B is consumed per cycle, most significant first.
module gf2m_digit_serial_mult
  import gf2m_pkg::*;
#(
  parameter int M     = 16,
  parameter int K2    = 5,
  parameter int K1    = 3,
  parameter int K0    = 2,
  parameter int TRI_K = 0,
  parameter int D     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [0:M-1] A_in,
  input  logic [0:M-1] B_in,
  input  logic [0:M-1] C_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:M-1] C_out,
  output logic         busy
);

  localparam int NDIG = calc_ndig(M, D);
  localparam int BW   = NDIG * D;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_e        state_q, state_d;
  logic [M-1:0]  a_vec, b_vec, c_vec;
  logic [M-1:0]  a_q, c_q, acc_q, res_q, step_acc;
  logic [BW-1:0] b_q;
  logic          mac_q;
  logic [CW-1:0] cnt_q;

  // Ports are declared [0:M-1]; index i is the x^i coefficient on both sides.
  for (genvar gi = 0; gi < M; gi++) begin : g_bitorder
    assign a_vec[gi] = A_in[gi];
    assign b_vec[gi] = B_in[gi];
    assign c_vec[gi] = C_in[gi];
    assign C_out[gi] = res_q[gi];
  end

  gf2m_digit_step #(
    .M(M), .K2(K2), .K1(K1), .K0(K0), .TRI_K(TRI_K), .D(D)
  ) u_step (
    .acc_i  (acc_q),
    .a_i    (a_q),
    .digit_i(b_q[BW-1 -: D]),
    .acc_o  (step_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_CALC;
      end
      ST_CALC: begin
        busy = 1'b1;
        if (cnt_q == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // B is zero-extended to whole digits and shifted left so the active digit is always on top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      mac_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q   <= a_vec;
            b_q   <= BW'((op == OP_SQR) ? a_vec : b_vec);
            c_q   <= c_vec;
            mac_q <= (op == OP_MAC);
            acc_q <= '0;
            cnt_q <= CW'(NDIG - 1);
          end
        end
        ST_CALC: begin
          acc_q <= step_acc;
          b_q   <= b_q << D;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) res_q <= step_acc ^ (mac_q ? c_q : '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2m_digit_serial_mult.sv
// Bench for gf2m_digit_serial_mult: vector table through a scoreboard on the D=4
// instance, plus latency sweeps over D=1/16/5 and back-pressure / reset sequences.
module tb_gf2m_digit_serial_mult;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_SQR = 2'b01;
  localparam logic [1:0] OP_MAC = 2'b10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_q[$];
  string       name_q[$];

  // shared operand bus (numeric form, bit i = x^i)
  logic [1:0]  op_s = OP_MUL;
  logic [15:0] a_num = '0, b_num = '0, c_num = '0;
  logic [0:15] a_port, b_port, c_port;

  function automatic logic [0:15] to_port(input logic [15:0] v);
    logic [0:15] p;
    for (int i = 0; i < 16; i++) p[i] = v[i];
    return p;
  endfunction

  function automatic logic [15:0] to_num(input logic [0:15] p);
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = p[i];
    return v;
  endfunction

  // reference: full carry-less product, then long-division by x^16+x^5+x^3+x^2+1
  function automatic logic [15:0] gf_ref(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < 16; i++) if (b[i]) p = p ^ ({16'h0, a} << i);
    for (int i = 30; i >= 16; i--) if (p[i]) p = p ^ (32'h0001_002D << (i - 16));
    return p[15:0];
  endfunction

  assign a_port = to_port(a_num);
  assign b_port = to_port(b_num);
  assign c_port = to_port(c_num);

  // main instance, D=4
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, busy;
  logic [0:15] cout_p;
  logic [15:0] cout_num;
  assign cout_num = to_num(cout_p);

  gf2m_digit_serial_mult #(.M(16), .K2(5), .K1(3), .K0(2), .TRI_K(0), .D(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op_s),
    .A_in(a_port), .B_in(b_port), .C_in(c_port), .out_valid(out_valid),
    .out_ready(out_ready), .C_out(cout_p), .busy(busy)
  );

  // digit-size sweep instances: D=1, D=16, D=5
  logic        x0_iv = 1'b0, x1_iv = 1'b0, x2_iv = 1'b0;
  logic        x0_ir, x1_ir, x2_ir, x0_ov, x1_ov, x2_ov, x0_bz, x1_bz, x2_bz;
  logic [0:15] x0_cp, x1_cp, x2_cp;

  gf2m_digit_serial_mult #(.M(16), .K2(5), .K1(3), .K0(2), .TRI_K(0), .D(1)) dut_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(x0_iv), .in_ready(x0_ir), .op(op_s),
    .A_in(a_port), .B_in(b_port), .C_in(c_port), .out_valid(x0_ov),
    .out_ready(1'b1), .C_out(x0_cp), .busy(x0_bz)
  );
  gf2m_digit_serial_mult #(.M(16), .K2(5), .K1(3), .K0(2), .TRI_K(0), .D(16)) dut_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(x1_iv), .in_ready(x1_ir), .op(op_s),
    .A_in(a_port), .B_in(b_port), .C_in(c_port), .out_valid(x1_ov),
    .out_ready(1'b1), .C_out(x1_cp), .busy(x1_bz)
  );
  gf2m_digit_serial_mult #(.M(16), .K2(5), .K1(3), .K0(2), .TRI_K(0), .D(5)) dut_d5 (
    .clk(clk), .rst_n(rst_n), .in_valid(x2_iv), .in_ready(x2_ir), .op(op_s),
    .A_in(a_port), .B_in(b_port), .C_in(c_port), .out_valid(x2_ov),
    .out_ready(1'b1), .C_out(x2_cp), .busy(x2_bz)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, expv);
    end else begin
      $display("[TB] ok   %s = 0x%0h", nm, got);
    end
  endtask

  // scoreboard: pops on every cycle the main instance completes an output handshake
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {16'h0, cout_num}, 32'hDEAD_BEEF);
      end else begin
        check(name_q.pop_front(), {16'h0, cout_num}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic scramble();
    a_num = 16'($urandom);
    b_num = 16'($urandom);
    c_num = 16'($urandom);
    op_s  = 2'($urandom);
  endtask

  // called at posedge+1; returns at posedge+1 after the result has been consumed
  task automatic drive_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] expv, input string nm);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
    if (!in_ready) check({nm, "_ready_timeout"}, 0, 1);
    op_s = o; a_num = a; b_num = b; c_num = c;
    in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(expv);
    name_q.push_back(nm);
    #1;
    in_valid = 1'b0;
    scramble();
    check({nm, "_busy"}, {30'h0, busy, in_ready}, 32'h2);
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    check({nm, "_latency"}, lat, 4);
    w = 0;
    while (exp_q.size() != 0 && w < 50) begin @(posedge clk); #1; w++; end
    if (exp_q.size() != 0) begin
      check({nm, "_drain_timeout"}, exp_q.size(), 0);
      exp_q.delete();
      name_q.delete();
    end
  endtask

  task automatic run_x(input int k, input int exp_lat, input string nm);
    int lat;
    int w;
    logic ir, ov;
    logic [15:0] cv;
    w = 0;
    ir = (k == 0) ? x0_ir : (k == 1) ? x1_ir : x2_ir;
    while (!ir && w < 50) begin
      @(posedge clk); #1; w++;
      ir = (k == 0) ? x0_ir : (k == 1) ? x1_ir : x2_ir;
    end
    op_s = OP_MUL; a_num = 16'h0001; b_num = 16'h1234; c_num = 16'hFFFF;
    case (k)
      0: x0_iv = 1'b1;
      1: x1_iv = 1'b1;
      default: x2_iv = 1'b1;
    endcase
    @(posedge clk); #1;
    x0_iv = 1'b0; x1_iv = 1'b0; x2_iv = 1'b0;
    scramble();
    lat = 0;
    ov = (k == 0) ? x0_ov : (k == 1) ? x1_ov : x2_ov;
    while (!ov && lat < 200) begin
      @(posedge clk); #1; lat++;
      ov = (k == 0) ? x0_ov : (k == 1) ? x1_ov : x2_ov;
    end
    cv = (k == 0) ? to_num(x0_cp) : (k == 1) ? to_num(x1_cp) : to_num(x2_cp);
    check({nm, "_latency"}, lat, exp_lat);
    check({nm, "_value"}, {16'h0, cv}, 32'h1234);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [15:0] expv;
    string       name;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat;
    logic [15:0] ra, rb, rc;

    vecs[0] = '{OP_MUL, 16'h8000, 16'h0002, 16'h0000, 16'h002D, "mul_x15_x"};
    vecs[1] = '{OP_MUL, 16'h0001, 16'h1234, 16'h0000, 16'h1234, "mul_one"};
    vecs[2] = '{OP_SQR, 16'h8000, 16'hFFFF, 16'h0000, 16'h411F, "sqr_x15"};
    vecs[3] = '{OP_MAC, 16'h8000, 16'h0002, 16'h00FF, 16'h00D2, "mac_x15_x"};
    for (int i = 4; i < 8; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 16'($urandom);
      vecs[i].op = 2'(i - 4);
      vecs[i].a  = ra;
      vecs[i].b  = rb;
      vecs[i].c  = rc;
      case (2'(i - 4))
        OP_SQR:  vecs[i].expv = gf_ref(ra, ra);
        OP_MAC:  vecs[i].expv = gf_ref(ra, rb) ^ rc;
        default: vecs[i].expv = gf_ref(ra, rb);
      endcase
      vecs[i].name = $sformatf("rand_%0d_op%0d", i, i - 4);
    end

    #2;
    check("reset_outputs", {13'h0, in_ready, out_valid, busy, cout_num}, {13'h0, 3'b100, 16'h0});
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) drive_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].expv, vecs[i].name);

    run_x(0, 16, "mul_one_d1");
    run_x(1, 1,  "mul_one_d16");
    run_x(2, 4,  "mul_one_d5");

    // back-pressure: result held, competing request ignored until after handshake
    out_ready = 1'b0;
    op_s = OP_MUL; a_num = 16'h8000; b_num = 16'h0002; c_num = 16'h0000;
    in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(16'h002D);
    name_q.push_back("bp_result");
    #1;
    op_s = OP_MUL; a_num = 16'h0003; b_num = 16'h0003; c_num = 16'h1111;
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    check("bp_latency", lat, 4);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold_%0d", i), {14'h0, out_valid, in_ready, cout_num}, {14'h0, 2'b10, 16'h002D});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_after_handshake", {30'h0, out_valid, in_ready}, 32'h1);
    @(posedge clk);
    exp_q.push_back(16'h0005);
    name_q.push_back("bp_second_op");
    #1;
    in_valid = 1'b0;
    check("bp_second_accepted", {31'h0, busy}, 32'h1);
    lat = 0;
    while (exp_q.size() != 0 && lat < 50) begin @(posedge clk); #1; lat++; end
    check("bp_drain", exp_q.size(), 0);

    // asynchronous reset two cycles into CALC aborts without producing a result
    op_s = OP_MUL; a_num = 16'h1234; b_num = 16'h5678; c_num = 16'h0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {13'h0, in_ready, out_valid, busy, cout_num}, {13'h0, 3'b100, 16'h0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("reset_no_result", {31'h0, out_valid}, 32'h0);
    drive_op(OP_MUL, 16'h0003, 16'h0003, 16'h0000, 16'h0005, "post_reset_mul");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
